image_loader: RTL and testbench

- Upstream feeder for the video stage's image memories.
- Accepts a byte stream from the host/bridge side and packs it into pixel writes on the shared image write bus.
- Background data is RGB565: two bytes per pixel, low byte first. Spritesheet data is 8-bit alpha: one byte per entry.
- Sequences addresses, strobes the correct write enable, and reports completion and abort.

---
 rtl/image_loader_if.sv | 28 ++
 rtl/image_loader.sv | 124 ++++++++++++
 tb/tb_image_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/image_loader_if.sv
// Control, byte-stream and image write bus bundle for image_loader.
// The host drives through master; the loader uses slave.
interface image_loader_if;
    logic        start;
    logic        target;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        background_write_en;
    logic        spritesheet_write_en;
    logic [16:0] image_write_addr;
    logic [15:0] image_write_data;
    logic        busy;
    logic        done;

    modport master (
        output start, target, abort, in_valid, in_data,
        input  in_ready, background_write_en, spritesheet_write_en,
        input  image_write_addr, image_write_data, busy, done
    );

    modport slave (
        input  start, target, abort, in_valid, in_data,
        output in_ready, background_write_en, spritesheet_write_en,
        output image_write_addr, image_write_data, busy, done
    );
endinterface

// File: rtl/image_loader.sv
// Packs a host byte stream into RGB565 background words or 8-bit spritesheet entries.
// Sequences write addresses and reports completion and abort.
module image_loader #(
    parameter logic [16:0] BACKGROUND_PIXELS = 17'd129600,
    parameter logic [16:0] SPRITESHEET_BYTES = 17'd32768
) (
    input logic           clk,
    input logic           reset_n,
    image_loader_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StBgLo, StBgHi, StSpr, StFinish} state_e;

    state_e      state_q, state_d;
    logic [16:0] cnt_q, cnt_d;
    logic [7:0]  lo_q, lo_d;
    logic        in_ready_q, in_ready_d;
    logic        bg_we_q, bg_we_d;
    logic        spr_we_q, spr_we_d;
    logic [16:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        hs;

    // in_ready is registered, so it mirrors the current state being a load state
    assign hs = bus.in_valid && in_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        bg_we_d  = 1'b0;
        spr_we_d = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    cnt_d   = '0;
                    state_d = bus.target ? StSpr : StBgLo;
                end
            end
            StBgLo: begin
                if (hs) begin
                    lo_d    = bus.in_data;
                    state_d = StBgHi;
                end
            end
            StBgHi: begin
                if (hs) begin
                    bg_we_d = 1'b1;
                    addr_d  = cnt_q;
                    data_d  = {bus.in_data, lo_q};
                    cnt_d   = cnt_q + 17'd1;
                    state_d = (cnt_q == BACKGROUND_PIXELS - 17'd1) ? StFinish : StBgLo;
                end
            end
            StSpr: begin
                if (hs) begin
                    spr_we_d = 1'b1;
                    addr_d   = cnt_q;
                    data_d   = {8'h00, bus.in_data};
                    cnt_d    = cnt_q + 17'd1;
                    state_d  = (cnt_q == SPRITESHEET_BYTES - 17'd1) ? StFinish : StSpr;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Abort drops any byte taken this cycle and the pending low byte
        if (bus.abort && state_q != StIdle) begin
            state_d  = StIdle;
            lo_d     = '0;
            bg_we_d  = 1'b0;
            spr_we_d = 1'b0;
            addr_d   = addr_q;
            data_d   = data_q;
            done_d   = 1'b0;
        end

        in_ready_d = (state_d == StBgLo) || (state_d == StBgHi) || (state_d == StSpr);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            lo_q       <= '0;
            in_ready_q <= 1'b0;
            bg_we_q    <= 1'b0;
            spr_we_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            in_ready_q <= in_ready_d;
            bg_we_q    <= bg_we_d;
            spr_we_q   <= spr_we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready             = in_ready_q;
    assign bus.background_write_en  = bg_we_q;
    assign bus.spritesheet_write_en = spr_we_q;
    assign bus.image_write_addr     = addr_q;
    assign bus.image_write_data     = data_q;
    assign bus.busy                 = busy_q;
    assign bus.done                 = done_q;
endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader with small load sizes; a scoreboard queue holds
// the expected write strobes and a negedge monitor pops and compares them.
module tb_image_loader;
    typedef struct packed {
        logic        spr;
        logic [16:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   done_seen;
    wr_t  exp_q[$];

    image_loader_if bus ();

    image_loader #(
        .BACKGROUND_PIXELS(17'd4),
        .SPRITESHEET_BYTES(17'd3)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic spr, input logic [16:0] addr, input logic [15:0] data);
        wr_t w;
        w.spr  = spr;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic start_load(input logic tgt);
        bus.start  = 1'b1;
        bus.target = tgt;
        step();
        bus.start  = 1'b0;
    endtask

    // Holds the byte until in_ready, then lets one edge consume it
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (n == 50) check("in_ready_timeout", 32'd0, 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.background_write_en === 1'b1 || bus.spritesheet_write_en === 1'b1) begin
            wr_t w;
            check("enables_exclusive",
                  {31'd0, bus.background_write_en & bus.spritesheet_write_en}, 32'd0);
            check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("strobe_kind", {31'd0, bus.spritesheet_write_en}, {31'd0, w.spr});
                check("write_addr", {15'd0, bus.image_write_addr}, {15'd0, w.addr});
                check("write_data", {16'd0, bus.image_write_data}, {16'd0, w.data});
            end
        end
        if (bus.done === 1'b1) done_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        done_seen    = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.target   = 1'b0;
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        step();
        step();
        reset_n = 1'b1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_bg_we", {31'd0, bus.background_write_en}, 32'd0);
        check("rst_spr_we", {31'd0, bus.spritesheet_write_en}, 32'd0);
        check("rst_addr", {15'd0, bus.image_write_addr}, 32'd0);
        check("rst_data", {16'd0, bus.image_write_data}, 32'd0);

        // Background load, continuous stream
        start_load(1'b0);
        check("bg_busy_rise", {31'd0, bus.busy}, 32'd1);
        check("bg_in_ready", {31'd0, bus.in_ready}, 32'd1);
        push(1'b0, 17'd0, 16'h0201);
        push(1'b0, 17'd1, 16'h0403);
        push(1'b0, 17'd2, 16'h0605);
        push(1'b0, 17'd3, 16'h0807);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        check("bg_last_strobe", {31'd0, bus.background_write_en}, 32'd1);
        check("bg_finish_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        check("bg_done", {31'd0, bus.done}, 32'd1);
        check("bg_busy_low", {31'd0, bus.busy}, 32'd0);
        step();
        check("bg_done_once", {31'd0, bus.done}, 32'd0);

        // Spritesheet load with a two-cycle gap after the first byte
        start_load(1'b1);
        push(1'b1, 17'd0, 16'h00AA);
        push(1'b1, 17'd1, 16'h00BB);
        push(1'b1, 17'd2, 16'h00CC);
        send_byte(8'hAA);
        step();
        step();
        send_byte(8'hBB);
        send_byte(8'hCC);
        check("spr_ready_after_last", {31'd0, bus.in_ready}, 32'd0);
        step();
        check("spr_done", {31'd0, bus.done}, 32'd1);
        step();

        // Abort with a low byte pending, then restart from address 0
        start_load(1'b0);
        push(1'b0, 17'd0, 16'h0201);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        check("abort_no_done", {31'd0, bus.done}, 32'd0);
        start_load(1'b0);
        push(1'b0, 17'd0, 16'h0605);
        send_byte(8'h05);
        send_byte(8'h06);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        step();

        // start with target=1 during a background load is ignored
        start_load(1'b0);
        push(1'b0, 17'd0, 16'h1211);
        push(1'b0, 17'd1, 16'h1413);
        push(1'b0, 17'd2, 16'h1615);
        push(1'b0, 17'd3, 16'h1817);
        send_byte(8'h11);
        send_byte(8'h12);
        bus.start  = 1'b1;
        bus.target = 1'b1;
        send_byte(8'h13);
        bus.start  = 1'b0;
        for (int i = 8'h14; i <= 8'h18; i++) send_byte(8'(i));
        step();
        check("restart_ignored_done", {31'd0, bus.done}, 32'd1);
        step();

        // Reset mid spritesheet load, with a byte offered in the reset cycle
        start_load(1'b1);
        push(1'b1, 17'd0, 16'h0055);
        send_byte(8'h55);
        reset_n      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h66;
        step();
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        check("mid_rst_bg_we", {31'd0, bus.background_write_en}, 32'd0);
        check("mid_rst_spr_we", {31'd0, bus.spritesheet_write_en}, 32'd0);
        check("mid_rst_addr", {15'd0, bus.image_write_addr}, 32'd0);
        check("mid_rst_data", {16'd0, bus.image_write_data}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        check("mid_rst_done", {31'd0, bus.done}, 32'd0);
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        check("mid_rst_ready_stays", {31'd0, bus.in_ready}, 32'd0);

        // start and abort together in IDLE
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        bus.target = 1'b0;
        step();
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        check("idle_abort_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_abort_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        check("idle_abort_busy2", {31'd0, bus.busy}, 32'd0);
        check("idle_abort_ready2", {31'd0, bus.in_ready}, 32'd0);

        step();
        step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("done_pulse_count", done_seen, 32'd3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
